// File: rtl/alu_ctrl_dmem_pkg.sv
// Shared encodings for the execute/memory slice: opcodes, R-type functs and ALU operations.
package alu_ctrl_dmem_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_JR  = 6'b001000;

    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_OR   = 3'b001,
        ALU_ADD  = 3'b010,
        ALU_ZERO = 3'b011,
        ALU_ANDN = 3'b100,
        ALU_ORN  = 3'b101,
        ALU_SUB  = 3'b110,
        ALU_SLT  = 3'b111
    } alu_op_e;

endpackage

// File: rtl/alu_ctrl_dmem_alu.sv
// 32-bit ALU with zero flag; add/sub wrap modulo 2^32 without an overflow trap.
module alu
    import alu_ctrl_dmem_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  alu_control,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = '0;
        case (alu_op_e'(alu_control))
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_ADD:  result = a + b;
            ALU_ZERO: result = '0;
            ALU_ANDN: result = a & ~b;
            ALU_ORN:  result = a | ~b;
            ALU_SUB:  result = a - b;
            ALU_SLT:  result = {31'd0, $signed(a) < $signed(b)};
            default:  result = '0;
        endcase
    end

    assign zero = (result == 32'd0);

endmodule

// File: rtl/alu_ctrl_dmem_control_unit.sv
// Main and ALU control decoder: opcode/funct to control strobes and ALU operation.
module control_unit
    import alu_ctrl_dmem_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       RegtoPC,
    output logic       Jump,
    output logic       LeaveLink,
    output logic       RegWrite,
    output logic       MemtoReg,
    output logic       MemWrite,
    output logic [2:0] ALUControl,
    output logic       ALUSrc,
    output logic       RegDst,
    output logic       Branch,
    output logic       ToggleEqual
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        RegtoPC     = 1'b0;
        Jump        = 1'b0;
        LeaveLink   = 1'b0;
        RegWrite    = 1'b0;
        MemtoReg    = 1'b0;
        MemWrite    = 1'b0;
        ALUControl  = ALU_ADD;
        ALUSrc      = 1'b0;
        RegDst      = 1'b0;
        Branch      = 1'b0;
        ToggleEqual = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    F_ADD: begin RegWrite = 1'b1; RegDst = 1'b1; ALUControl = ALU_ADD; end
                    F_SUB: begin RegWrite = 1'b1; RegDst = 1'b1; ALUControl = ALU_SUB; end
                    F_AND: begin RegWrite = 1'b1; RegDst = 1'b1; ALUControl = ALU_AND; end
                    F_OR:  begin RegWrite = 1'b1; RegDst = 1'b1; ALUControl = ALU_OR;  end
                    F_SLT: begin RegWrite = 1'b1; RegDst = 1'b1; ALUControl = ALU_SLT; end
                    F_JR:  begin RegtoPC  = 1'b1; Jump   = 1'b1; end
                    default: ;
                endcase
            end
            OP_LW:   begin RegWrite = 1'b1; ALUSrc = 1'b1; MemtoReg = 1'b1; end
            OP_SW:   begin ALUSrc = 1'b1; MemWrite = 1'b1; end
            OP_BEQ:  begin Branch = 1'b1; ALUControl = ALU_SUB; end
            OP_BNE:  begin Branch = 1'b1; ToggleEqual = 1'b1; ALUControl = ALU_SUB; end
            OP_ADDI: begin RegWrite = 1'b1; ALUSrc = 1'b1; end
            OP_SLTI: begin RegWrite = 1'b1; ALUSrc = 1'b1; ALUControl = ALU_SLT; end
            OP_J:    begin Jump = 1'b1; end
            OP_JAL:  begin Jump = 1'b1; LeaveLink = 1'b1; RegWrite = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_dmem_data_mem.sv
// Word-addressed data memory: asynchronous read, rising-edge write, asynchronous clear.
module data_mem_dis #(
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    localparam int DEPTH = 1 << AW;

    logic [31:0] mem_q [DEPTH];

    // NOTE: the memory is built from flops and cleared by reset because load data must read 0
    // during and after reset; a RAM macro could not offer that.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            // NOTE: non-blocking so a same-cycle read keeps seeing the old word until the edge.
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = rstn ? mem_q[addr] : 32'd0;

endmodule

// File: rtl/alu_ctrl_dmem.sv
// Execute/memory slice of the single-cycle core: decoder, ALU and data memory.
module alu_ctrl_dmem
    import alu_ctrl_dmem_pkg::*;
#(
    parameter int DMEM_AW = 6
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [31:0] alu_srcA,
    input  logic [31:0] alu_srcB,
    input  logic [31:0] store_data,
    output logic        RegtoPC,
    output logic        Jump,
    output logic        LeaveLink,
    output logic        RegWrite,
    output logic        MemtoReg,
    output logic        MemWrite,
    output logic [2:0]  ALUControl,
    output logic        ALUSrc,
    output logic        RegDst,
    output logic        Branch,
    output logic        ToggleEqual,
    output logic [31:0] alu_result,
    output logic        zero,
    output logic [31:0] load_data
);

    control_unit u_ctrl (
        .opcode      (opcode),
        .funct       (funct),
        .RegtoPC     (RegtoPC),
        .Jump        (Jump),
        .LeaveLink   (LeaveLink),
        .RegWrite    (RegWrite),
        .MemtoReg    (MemtoReg),
        .MemWrite    (MemWrite),
        .ALUControl  (ALUControl),
        .ALUSrc      (ALUSrc),
        .RegDst      (RegDst),
        .Branch      (Branch),
        .ToggleEqual (ToggleEqual)
    );

    alu u_alu (
        .a           (alu_srcA),
        .b           (alu_srcB),
        .alu_control (ALUControl),
        .result      (alu_result),
        .zero        (zero)
    );

    // Byte address from the ALU; only the word-index bits reach the memory, so addresses wrap.
    data_mem_dis #(
        .AW (DMEM_AW)
    ) u_dmem (
        .clk   (clk),
        .rstn  (rstn),
        .we    (MemWrite),
        .addr  (alu_result[DMEM_AW+1:2]),
        .wdata (store_data),
        .rdata (load_data)
    );

endmodule

// File: tb/tb_alu_ctrl_dmem.sv
// Directed self-checking bench for alu_ctrl_dmem with hand-computed expected values.
module tb_alu_ctrl_dmem;

    logic        clk = 1'b0;
    logic        rstn;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] alu_srcA;
    logic [31:0] alu_srcB;
    logic [31:0] store_data;
    logic        RegtoPC, Jump, LeaveLink, RegWrite, MemtoReg, MemWrite;
    logic [2:0]  ALUControl;
    logic        ALUSrc, RegDst, Branch, ToggleEqual;
    logic [31:0] alu_result;
    logic        zero;
    logic [31:0] load_data;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    alu_ctrl_dmem #(.DMEM_AW(6)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .opcode      (opcode),
        .funct       (funct),
        .alu_srcA    (alu_srcA),
        .alu_srcB    (alu_srcB),
        .store_data  (store_data),
        .RegtoPC     (RegtoPC),
        .Jump        (Jump),
        .LeaveLink   (LeaveLink),
        .RegWrite    (RegWrite),
        .MemtoReg    (MemtoReg),
        .MemWrite    (MemWrite),
        .ALUControl  (ALUControl),
        .ALUSrc      (ALUSrc),
        .RegDst      (RegDst),
        .Branch      (Branch),
        .ToggleEqual (ToggleEqual),
        .alu_result  (alu_result),
        .zero        (zero),
        .load_data   (load_data)
    );

    // Strobe order: RegtoPC Jump LeaveLink RegWrite MemtoReg MemWrite ALUSrc RegDst Branch ToggleEqual
    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] fn;
        logic [9:0] strobes;
        logic [2:0] aluc;
        bit         chk_aluc;
    } dec_vec_t;

    task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] sd);
        opcode = op; funct = fn; alu_srcA = a; alu_srcB = b; store_data = sd;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        drive(6'b000000, 6'b000000, 32'd0, 32'd0, 32'd0);
        #2;
        tests_run++;
        if (load_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_load_addr0: got %h expected %h", load_data, 32'd0);
        end
        drive(6'b100011, 6'b000000, 32'h4, 32'd0, 32'd0);
        #1;
        tests_run++;
        if (load_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_load_addr4: got %h expected %h", load_data, 32'd0);
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_decode();
        dec_vec_t v [16];
        logic [9:0] got;
        v[0]  = '{"add",  6'b000000, 6'b100000, 10'b0001000100, 3'b010, 1'b1};
        v[1]  = '{"sub",  6'b000000, 6'b100010, 10'b0001000100, 3'b110, 1'b1};
        v[2]  = '{"and",  6'b000000, 6'b100100, 10'b0001000100, 3'b000, 1'b1};
        v[3]  = '{"or",   6'b000000, 6'b100101, 10'b0001000100, 3'b001, 1'b1};
        v[4]  = '{"slt",  6'b000000, 6'b101010, 10'b0001000100, 3'b111, 1'b1};
        v[5]  = '{"jr",   6'b000000, 6'b001000, 10'b1100000000, 3'b000, 1'b0};
        v[6]  = '{"lw",   6'b100011, 6'b000000, 10'b0001101000, 3'b010, 1'b1};
        v[7]  = '{"sw",   6'b101011, 6'b000000, 10'b0000011000, 3'b010, 1'b1};
        v[8]  = '{"beq",  6'b000100, 6'b000000, 10'b0000000010, 3'b110, 1'b1};
        v[9]  = '{"bne",  6'b000101, 6'b000000, 10'b0000000011, 3'b110, 1'b1};
        v[10] = '{"addi", 6'b001000, 6'b000000, 10'b0001001000, 3'b010, 1'b1};
        v[11] = '{"slti", 6'b001010, 6'b000000, 10'b0001001000, 3'b111, 1'b1};
        v[12] = '{"j",    6'b000010, 6'b000000, 10'b0100000000, 3'b000, 1'b0};
        v[13] = '{"jal",  6'b000011, 6'b000000, 10'b0111000000, 3'b000, 1'b0};
        v[14] = '{"op3f", 6'b111111, 6'b000000, 10'b0000000000, 3'b010, 1'b1};
        v[15] = '{"rbad", 6'b000000, 6'b000000, 10'b0000000000, 3'b010, 1'b1};
        for (int i = 0; i < 16; i++) begin
            drive(v[i].op, v[i].fn, 32'd0, 32'd0, 32'd0);
            #1;
            got = {RegtoPC, Jump, LeaveLink, RegWrite, MemtoReg, MemWrite,
                   ALUSrc, RegDst, Branch, ToggleEqual};
            tests_run++;
            if (got !== v[i].strobes) begin
                tests_failed++;
                $display("FAIL decode_%s_strobes: got %b expected %b", v[i].name, got, v[i].strobes);
            end
            if (v[i].chk_aluc) begin
                tests_run++;
                if (ALUControl !== v[i].aluc) begin
                    tests_failed++;
                    $display("FAIL decode_%s_aluc: got %b expected %b", v[i].name, ALUControl, v[i].aluc);
                end
            end
        end
    endtask

    task automatic test_alu();
        logic [31:0] a [6] = '{32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF, 32'd1, 32'hF0F0F0F0, 32'hF0F0F0F0};
        logic [31:0] b [6] = '{32'd1, 32'd5, 32'd1, 32'hFFFFFFFF, 32'h0FF00FF0, 32'h0FF00FF0};
        logic [5:0]  f [6] = '{6'b100000, 6'b100010, 6'b101010, 6'b101010, 6'b100100, 6'b100101};
        logic [31:0] r [6] = '{32'h80000000, 32'd0, 32'd1, 32'd0, 32'h00F000F0, 32'hFFF0FFF0};
        logic        z [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            drive(6'b000000, f[i], a[i], b[i], 32'd0);
            #1;
            tests_run++;
            if (alu_result !== r[i] || zero !== z[i]) begin
                tests_failed++;
                $display("FAIL alu_vec%0d: got result=%h zero=%b expected result=%h zero=%b",
                         i, alu_result, zero, r[i], z[i]);
            end
        end
    endtask

    task automatic test_store_load();
        @(negedge clk);
        drive(6'b100011, 6'd0, 32'h10, 32'd0, 32'd0);
        #1;
        tests_run++;
        if (load_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL preload_0x10: got %h expected %h", load_data, 32'd0);
        end
        drive(6'b101011, 6'd0, 32'h10, 32'd0, 32'hDEADBEEF);
        #1;
        tests_run++;
        if (load_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL same_cycle_old_word: got %h expected %h", load_data, 32'd0);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (load_data !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL store_visible_after_edge: got %h expected %h", load_data, 32'hDEADBEEF);
        end
        @(negedge clk);
        drive(6'b100011, 6'd0, 32'h10, 32'd0, 32'd0);
        #1;
        tests_run++;
        if (load_data !== 32'hDEADBEEF || MemtoReg !== 1'b1) begin
            tests_failed++;
            $display("FAIL lw_0x10: got %h memtoreg=%b expected %h memtoreg=1", load_data, MemtoReg, 32'hDEADBEEF);
        end
        drive(6'b100011, 6'd0, 32'h10 + 32'd256, 32'd0, 32'd0);
        #1;
        tests_run++;
        if (load_data !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL wrap_0x110: got %h expected %h", load_data, 32'hDEADBEEF);
        end
        drive(6'b100011, 6'd0, 32'h13, 32'd0, 32'd0);
        #1;
        tests_run++;
        if (load_data !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL low_bits_0x13: got %h expected %h", load_data, 32'hDEADBEEF);
        end
        drive(6'b100011, 6'd0, 32'h14, 32'd0, 32'd0);
        #1;
        tests_run++;
        if (load_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL neighbour_0x14: got %h expected %h", load_data, 32'd0);
        end
    endtask

    task automatic test_no_write();
        logic [31:0] exp [2] = '{32'h11111111, 32'h22222222};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(6'b101011, 6'd0, 32'h20 + 32'(i * 4), 32'd0, exp[i]);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive((i % 2 == 0) ? 6'b100011 : 6'b111111, 6'd0,
                  32'h20 + 32'((i % 2) * 4), 32'd0, 32'hA5A50000 + 32'(i));
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(6'b100011, 6'd0, 32'h20 + 32'(i * 4), 32'd0, 32'd0);
            #1;
            tests_run++;
            if (load_data !== exp[i]) begin
                tests_failed++;
                $display("FAIL nowrite_word%0d: got %h expected %h", i, load_data, exp[i]);
            end
        end
    endtask

    task automatic test_reset_clear();
        @(negedge clk);
        drive(6'b101011, 6'd0, 32'h4, 32'd0, 32'h12345678);
        @(posedge clk);
        #1;
        tests_run++;
        if (load_data !== 32'h12345678) begin
            tests_failed++;
            $display("FAIL pre_reset_0x4: got %h expected %h", load_data, 32'h12345678);
        end
        drive(6'b100011, 6'd0, 32'h4, 32'd0, 32'd0);
        #1;
        rstn = 1'b0;
        #1;
        tests_run++;
        if (load_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL during_reset_0x4: got %h expected %h", load_data, 32'd0);
        end
        // Write attempt spanning a rising edge while reset is held.
        drive(6'b101011, 6'd0, 32'h4, 32'd0, 32'hCAFEF00D);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        #1;
        tests_run++;
        if (load_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL write_blocked_in_reset: got %h expected %h", load_data, 32'd0);
        end
        drive(6'b100011, 6'd0, 32'h10, 32'd0, 32'd0);
        #1;
        tests_run++;
        if (load_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_cleared_0x10: got %h expected %h", load_data, 32'd0);
        end
        // Reset released mid-cycle: the write lands at the next rising edge.
        drive(6'b101011, 6'd0, 32'h4, 32'd0, 32'h0BADF00D);
        @(posedge clk);
        #1;
        tests_run++;
        if (load_data !== 32'h0BADF00D) begin
            tests_failed++;
            $display("FAIL first_write_after_reset: got %h expected %h", load_data, 32'h0BADF00D);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_alu();
        test_store_load();
        test_no_write();
        test_reset_clear();
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
